// File: rtl/shift_add_multiplier.sv
// Sequential unsigned N x N -> 2N multiplier: one ripple add-and-shift per clock,
// operands and product exchanged over valid/ready handshakes.
module shift_add_multiplier #(
  parameter int unsigned N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   input_a,
  input  logic [N-1:0]   input_b,
  input  logic           input_valid,
  output logic           input_ready,
  output logic [2*N-1:0] output_product,
  output logic           output_valid,
  input  logic           output_ready
);

  localparam int unsigned CntW = $clog2(N) + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q;
  logic [N-1:0]    a_q, hi_q, lo_q;
  logic [CntW-1:0] count_q;

  logic [N-1:0] add_s;
  logic         add_c;
  logic [N-1:0] acc_s;
  logic         acc_c;

  // N-bit ripple adder, carry-in tied to 0; carry walks bit by bit.
  always_comb begin
    logic c;
    add_s = '0;
    c     = 1'b0;
    for (int i = 0; i < N; i++) begin
      add_s[i] = hi_q[i] ^ a_q[i] ^ c;
      c        = (hi_q[i] & a_q[i]) | (c & (hi_q[i] ^ a_q[i]));
    end
    add_c = c;
  end

  assign acc_c = lo_q[0] ? add_c : 1'b0;
  assign acc_s = lo_q[0] ? add_s : hi_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      count_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (input_valid) begin
            a_q     <= input_a;
            hi_q    <= '0;
            lo_q    <= input_b;
            count_q <= '0;
            state_q <= StRun;
          end
        end
        StRun: begin
          // Carry lands in hi[N-1]; the bit shifted out of hi enters lo from the top.
          hi_q    <= {acc_c, acc_s[N-1:1]};
          lo_q    <= {acc_s[0], lo_q[N-1:1]};
          count_q <= count_q + CntW'(1);
          if (count_q == LastCnt) state_q <= StDone;
        end
        StDone: begin
          if (output_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign output_product = {hi_q, lo_q};
  assign input_ready    = (state_q == StIdle);
  assign output_valid   = (state_q == StDone);

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed and random checks of shift_add_multiplier at N=8 and N=4.
module tb_shift_add_multiplier;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  input_a, input_b;
  logic        input_valid, input_ready, output_valid, output_ready;
  logic [15:0] output_product;

  logic [3:0]  a4, b4;
  logic        iv4, ir4, ov4, or4;
  logic [7:0]  p4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  shift_add_multiplier #(.N(8)) u_dut8 (
    .clk            (clk),
    .rst            (rst),
    .input_a        (input_a),
    .input_b        (input_b),
    .input_valid    (input_valid),
    .input_ready    (input_ready),
    .output_product (output_product),
    .output_valid   (output_valid),
    .output_ready   (output_ready)
  );

  shift_add_multiplier #(.N(4)) u_dut4 (
    .clk            (clk),
    .rst            (rst),
    .input_a        (a4),
    .input_b        (b4),
    .input_valid    (iv4),
    .input_ready    (ir4),
    .output_product (p4),
    .output_valid   (ov4),
    .output_ready   (or4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after acceptance.
  task automatic start_op(input logic [7:0] a, input logic [7:0] b);
    check("ready_before_accept", 32'(input_ready), 32'd1);
    input_a     = a;
    input_b     = b;
    input_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    input_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!output_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  // Full op with output_ready already high: checks latency, product, one-cycle valid.
  task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] exp);
    int lat;
    start_op(a, b);
    wait_done(lat);
    check({tag, "_latency"}, 32'(lat), 32'd8);
    check({tag, "_product"}, 32'(output_product), 32'(exp));
    @(posedge clk);
    @(negedge clk);
    check({tag, "_valid_drop"}, 32'(output_valid), 32'd0);
    check({tag, "_ready_back"}, 32'(input_ready), 32'd1);
  endtask

  initial begin
    int lat;
    int stall;
    int a, b;
    rst = 1'b1; input_a = 8'd0; input_b = 8'd0; input_valid = 1'b1; output_ready = 1'b0;
    a4 = 4'd0; b4 = 4'd0; iv4 = 1'b0; or4 = 1'b0;

    // Reset held with input_valid high
    @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(output_valid), 32'd0);
    check("rst_ready", 32'(input_ready), 32'd1);
    check("rst_product", 32'(output_product), 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    input_valid = 1'b0;
    check("rst_ready4", 32'(ir4), 32'd1);

    output_ready = 1'b1;
    do_op("mul_13x11", 8'd13, 8'd11, 16'h008F);
    do_op("mul_255x255", 8'd255, 8'd255, 16'hFE01);
    do_op("mul_0x200", 8'd0, 8'd200, 16'h0000);
    do_op("mul_200x0", 8'd200, 8'd0, 16'h0000);

    // Backpressure with new operands offered throughout
    output_ready = 1'b0;
    start_op(8'd13, 8'd11);
    input_a = 8'd2; input_b = 8'd2; input_valid = 1'b1;
    wait_done(lat);
    check("bp_latency", 32'(lat), 32'd8);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_valid_held", 32'(output_valid), 32'd1);
      check("bp_product_held", 32'(output_product), 32'h008F);
      check("bp_not_ready", 32'(input_ready), 32'd0);
    end
    output_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_idle_valid", 32'(output_valid), 32'd0);
    check("bp_idle_ready", 32'(input_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    input_valid = 1'b0;
    wait_done(lat);
    check("bp_2x2_latency", 32'(lat), 32'd8);
    check("bp_2x2_product", 32'(output_product), 32'h0004);
    @(posedge clk);
    @(negedge clk);

    // Reset on the 4th RUN edge
    start_op(8'd100, 8'd3);
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("midrst_valid", 32'(output_valid), 32'd0);
    check("midrst_ready", 32'(input_ready), 32'd1);
    check("midrst_product", 32'(output_product), 32'h0);
    do_op("mul_3x5", 8'd3, 8'd5, 16'h000F);

    // Random ops, N=8, with output stalls
    output_ready = 1'b0;
    for (int k = 0; k < 200; k++) begin
      a = int'($urandom_range(0, 255));
      b = int'($urandom_range(0, 255));
      start_op(8'(a), 8'(b));
      wait_done(lat);
      check("rnd8_latency", 32'(lat), 32'd8);
      check("rnd8_product", 32'(output_product), 32'(a * b));
      stall = int'($urandom_range(0, 3));
      repeat (stall) begin
        @(posedge clk);
        @(negedge clk);
        check("rnd8_stall_valid", 32'(output_valid), 32'd1);
        check("rnd8_stall_product", 32'(output_product), 32'(a * b));
      end
      output_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      output_ready = 1'b0;
      check("rnd8_no_dup", 32'(output_valid), 32'd0);
    end

    // Random ops, N=4
    for (int k = 0; k < 200; k++) begin
      a = int'($urandom_range(0, 15));
      b = int'($urandom_range(0, 15));
      check("rnd4_ready", 32'(ir4), 32'd1);
      a4 = 4'(a); b4 = 4'(b); iv4 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      iv4 = 1'b0;
      lat = 0;
      while (!ov4 && lat < 40) begin
        @(posedge clk);
        lat++;
        @(negedge clk);
      end
      check("rnd4_latency", 32'(lat), 32'd4);
      check("rnd4_product", 32'(p4), 32'(a * b));
      stall = int'($urandom_range(0, 3));
      repeat (stall) begin
        @(posedge clk);
        @(negedge clk);
        check("rnd4_stall_valid", 32'(ov4), 32'd1);
      end
      or4 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      or4 = 1'b0;
      check("rnd4_no_dup", 32'(ov4), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
